mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one data/instruction memory bus between two requesters: instruction fetch (IF) and the MEM-stage LSU.
- Sequences each access with a req/ack handshake to a variable-latency slave.
- Generates a pipeline stall while an LSU access is outstanding.
- Enforces a bus timeout that returns an error response.
- Sits between the IF/MA stages and the memory/peripheral bus.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width
TIMEOUT, 255, max cycles in a bus state without i_bus_ack before an error completion (1..2^16-1)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous active-low reset
i_if_req  in  1  fetch request; level, held until o_if_ready
i_if_addr  in  ADDR_W  fetch address
o_if_ready  out  1  one-cycle completion pulse for fetch
o_if_rdata  out  DATA_W  fetched word; valid with o_if_ready
o_if_err  out  1  fetch timed out; valid with o_if_ready
i_lsu_req  in  1  LSU request; level, held until o_lsu_ready
i_lsu_we  in  1  1 = store, 0 = load
i_lsu_addr  in  ADDR_W  LSU address
i_lsu_wdata  in  DATA_W  store data
i_lsu_be  in  DATA_W/8  byte enables
o_lsu_ready  out  1  one-cycle completion pulse for LSU
o_lsu_rdata  out  DATA_W  load data; valid with o_lsu_ready
o_lsu_err  out  1  LSU access timed out; valid with o_lsu_ready
o_stall  out  1  pipeline stall = i_lsu_req & ~o_lsu_ready (combinational)
o_bus_req  out  1  bus request, registered
o_bus_we  out  1  bus write enable
o_bus_addr  out  ADDR_W  bus address
o_bus_wdata  out  DATA_W  bus write data
o_bus_be  out  DATA_W/8  bus byte enables
i_bus_ack  in  1  slave completion, one-cycle pulse
i_bus_rdata  in  DATA_W  slave read data; valid with i_bus_ack

Behaviour:
- Reset (i_rst low, asynchronous):
  - State goes to IDLE; timeout counter cleared.
  - All outputs go to 0 except o_stall, which remains combinational.
- States: IDLE, BUS_IF, BUS_LSU, RESP.
- IDLE:
  - Arbitration is fixed priority, LSU over IF: the older instruction must drain.
  - If i_lsu_req: latch lsu addr/we/wdata/be onto the o_bus_* registers, set o_bus_req=1, go to BUS_LSU.
  - Else if i_if_req: latch i_if_addr, o_bus_we=0, o_bus_be all ones, o_bus_req=1, go to BUS_IF.
  - Else stay in IDLE.
- BUS_IF / BUS_LSU:
  - o_bus_* are held stable; the counter increments each cycle.
  - On i_bus_ack: capture i_bus_rdata into the owner's rdata register, clear o_bus_req, go to RESP with err=0.
  - If the counter reaches TIMEOUT with no ack: clear o_bus_req, owner rdata=0, err=1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
  - Stores return rdata=0.
- RESP:
  - Pulse the owner's o_*_ready for exactly one cycle; the non-owner's ready stays 0.
  - Return to IDLE; the counter clears.
  - A new grant is not issued in RESP, so each access takes at least 3 cycles: request in IDLE at N, bus_req at N+1, ack at earliest N+1, ready at N+2.
- rdata/err outputs hold their value until the next completion for that port.
- Requester drops req mid-transaction: the bus access still completes and ready still pulses; the requester ignores it. The bus is never abandoned except on timeout.
- i_bus_ack in IDLE or RESP is ignored.
- Changes to requester inputs after grant do not affect the bus: addresses and data are latched at grant.
- IF starvation under continuous LSU traffic is permitted; the pipeline is stalled in that case.

Decomposition:
- Shared package rv_bus_pkg holds:
  - arb_state_e (IDLE, BUS_IF, BUS_LSU, RESP);
  - the owner encoding (OWN_IF=0, OWN_LSU=1);
  - the default TIMEOUT constant.
- One sub-module: bus_timeout_cnt.
  - Inputs: clear and enable.
  - Output: expired, asserted when count == TIMEOUT.
  - Width is $clog2(TIMEOUT+1).

Test Plan:
- Single load: i_lsu_req, addr 0x100, we=0; slave acks 2 cycles after bus_req with 0xDEADBEEF. Required: o_lsu_ready pulses one cycle later, o_lsu_rdata=0xDEADBEEF, o_lsu_err=0, o_stall high until that pulse.
- Simultaneous requests: IF addr 0x0 and LSU store addr 0x200, wdata 0x12345678, be=0x3. Required: the LSU is served first with o_bus_we=1 and be=0x3; the IF access is issued after RESP; o_if_ready returns the slave data.
- Timeout with TIMEOUT=4: IF request, no ack. Required: o_bus_req drops after 4 cycles; o_if_ready=1, o_if_err=1, o_if_rdata=0.
- Ack on the timeout cycle: ack arrives exactly at count==TIMEOUT. Required: err=0 and rdata=slave data.
- Async reset mid-BUS_LSU: i_rst low for one half cycle. Required: o_bus_req=0 immediately, state IDLE, no ready pulse; a subsequent request completes normally.
- Back-to-back LSU: LSU req held across two accesses (addresses 0x10 then 0x14). Required: two distinct ready pulses with no bus_req overlap, separated by at least one non-bus cycle (RESP/IDLE).

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types for the IF/LSU memory bus arbiter: FSM states, owner encoding, default timeout.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_IF  = 2'd1,
    BUS_LSU = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating bus-wait counter; expired is a combinational decode of count == TIMEOUT.
// Clear has priority over enable; the count holds once expired.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && !o_expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority (LSU over IF) arbiter onto a req/ack memory bus; at least 3 cycles per access.
// Requesters hold req until their ready pulse; o_stall holds the pipeline while an LSU access is open.
module mem_bus_arbiter
  import rv_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ready,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_err,
  input  logic                i_lsu_req,
  input  logic                i_lsu_we,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_be,
  output logic                o_lsu_ready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_err,
  output logic                o_stall,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_be,
  input  logic                i_bus_ack,
  input  logic [DATA_W-1:0]   i_bus_rdata
);

  arb_state_e        state, state_nxt;
  logic              owner;
  logic              grant_lsu, grant_if, done;
  logic              cnt_clr, cnt_en, expired;
  logic [DATA_W-1:0] cap_rdata;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (cnt_clr),
    .i_en      (cnt_en),
    .o_expired (expired)
  );

  // The counter already runs in the grant cycle, so the bus is held for at most TIMEOUT cycles.
  always_comb begin
    state_nxt = state;
    grant_lsu = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (i_lsu_req) begin
          grant_lsu = 1'b1;
          cnt_en    = 1'b1;
          state_nxt = BUS_LSU;
        end else if (i_if_req) begin
          grant_if  = 1'b1;
          cnt_en    = 1'b1;
          state_nxt = BUS_IF;
        end else begin
          cnt_clr   = 1'b1;
        end
      end
      BUS_IF, BUS_LSU: begin
        cnt_en = 1'b1;
        if (i_bus_ack || expired) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stores and timeouts both complete with zero data.
  assign cap_rdata = (i_bus_ack && !o_bus_we) ? i_bus_rdata : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= '0;
      o_if_rdata  <= '0;
      o_if_err    <= 1'b0;
      o_lsu_rdata <= '0;
      o_lsu_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_lsu) begin
        owner       <= OWN_LSU;
        o_bus_req   <= 1'b1;
        o_bus_we    <= i_lsu_we;
        o_bus_addr  <= i_lsu_addr;
        o_bus_wdata <= i_lsu_wdata;
        o_bus_be    <= i_lsu_be;
      end else if (grant_if) begin
        owner       <= OWN_IF;
        o_bus_req   <= 1'b1;
        o_bus_we    <= 1'b0;
        o_bus_addr  <= i_if_addr;
        o_bus_wdata <= '0;
        o_bus_be    <= '1;
      end else if (done) begin
        o_bus_req   <= 1'b0;
      end
      if (done) begin
        if (owner == OWN_LSU) begin
          o_lsu_rdata <= cap_rdata;
          o_lsu_err   <= ~i_bus_ack;
        end else begin
          o_if_rdata  <= cap_rdata;
          o_if_err    <= ~i_bus_ack;
        end
      end
    end
  end

  assign o_if_ready  = (state == RESP) && (owner == OWN_IF);
  assign o_lsu_ready = (state == RESP) && (owner == OWN_LSU);
  assign o_stall     = i_lsu_req & ~o_lsu_ready;

endmodule
